servo_ramp_array: RTL and testbench

Parametrised multi-channel servo angle controller: accepts decoded voice/keypad commands over a valid/ready handshake, holds per-channel target angle and speed, and ramps each channel's output angle toward its target in fixed steps at a speed-dependent rate. It sits between the command decoder and the per-servo PWM generators. It replaces the single-channel fixed-table angle controller, adding:

- N channels
- explicit opcodes
- clamping
- step-size snapping
- stop/home
- per-channel busy/done status

---
 rtl/servo_pkg.sv | 29 ++
 rtl/servo_ramp_ch.sv | 153 +++++++++++++++
 rtl/servo_ramp_array.sv | 98 +++++++++
 tb/tb_servo_ramp_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared definitions for the multi-channel servo ramp controller.
//               It holds the command opcodes, the per-channel state type and the
//               default angle, speed and step constants.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

    // Command opcodes carried on iCmdOp
    localparam logic [1:0] OP_SET_ANGLE = 2'd0;
    localparam logic [1:0] OP_SET_SPEED = 2'd1;
    localparam logic [1:0] OP_STOP      = 2'd2;
    localparam logic [1:0] OP_HOME      = 2'd3;

    // Per-channel motion state
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ch_state_t;

    // Default reset/home angle, reset speed code and step size (degrees)
    localparam int c_HOME_ANGLE = 60;
    localparam int c_DEF_SPEED  = 2;
    localparam int c_STEP       = 5;

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_ramp_ch.sv
`default_nettype none
// ============================================================================
// Module      : servo_ramp_ch
// Description : One servo channel. It holds the target angle, the speed code and
//               the rate accumulator, and ramps the output angle toward the
//               target in steps of at most STEP degrees.
// Revision    : 1.0 - initial release
// Ports       : i_clk        clock, rising edge
//               i_rst        asynchronous active-high reset
//               i_cmd_valid  accepted command addressed to this channel
//               i_cmd_op     opcode (servo_pkg OP_*)
//               i_cmd_value  angle, or speed code in the low SPEED_W bits
//               o_angle      current output angle
//               o_busy       channel is ramping
//               o_done       one-cycle pulse after the target is reached
// ============================================================================
module servo_ramp_ch
    import servo_pkg::*;
#(
    parameter int ANGLE_W    = 8,
    parameter int MIN_ANGLE  = 0,
    parameter int MAX_ANGLE  = 180,
    parameter int HOME_ANGLE = c_HOME_ANGLE,
    parameter int STEP       = c_STEP,
    parameter int SPEED_W    = 3,
    parameter int DEF_SPEED  = c_DEF_SPEED,
    parameter int ACC_W      = 22
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd_op,
    input  logic [ANGLE_W-1:0] i_cmd_value,
    output logic [ANGLE_W-1:0] o_angle,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [ANGLE_W-1:0] c_HOME      = ANGLE_W'(HOME_ANGLE);
    localparam logic [ANGLE_W-1:0] c_MIN       = ANGLE_W'(MIN_ANGLE);
    localparam logic [ANGLE_W-1:0] c_MAX       = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W:0]   c_STEP_EXT  = (ANGLE_W+1)'(STEP);
    localparam logic [SPEED_W-1:0] c_SPEED_RST = SPEED_W'(DEF_SPEED);

    ch_state_t          r_state,  w_state_nxt;
    logic [ANGLE_W-1:0] r_angle,  w_angle_nxt;
    logic [ANGLE_W-1:0] r_target, w_target_nxt;
    logic [SPEED_W-1:0] r_speed,  w_speed_nxt;
    logic [ACC_W-1:0]   r_acc,    w_acc_nxt;
    logic               r_done,   w_done_nxt;

    logic [ANGLE_W-1:0] w_clamped;
    logic [ANGLE_W-1:0] w_new_tgt;
    logic [ANGLE_W-1:0] w_step_angle;
    logic [ANGLE_W:0]   w_diff;
    logic [ANGLE_W:0]   w_dist;
    logic [ANGLE_W:0]   w_move;
    logic [ANGLE_W:0]   w_sum;
    logic               w_up;
    logic               w_unused_msb;

    // Distance is taken one bit wider than the angle so the sign of
    // target-angle is available directly.
    assign w_diff = {1'b0, r_target} - {1'b0, r_angle};
    assign w_up   = ~w_diff[ANGLE_W];
    assign w_dist = w_up ? w_diff : ({1'b0, r_angle} - {1'b0, r_target});

    // Move by STEP or by the remaining distance, whichever is smaller, so the
    // final step lands exactly on the target.
    assign w_move       = (w_dist > c_STEP_EXT) ? c_STEP_EXT : w_dist;
    assign w_sum        = w_up ? ({1'b0, r_angle} + w_move) : ({1'b0, r_angle} - w_move);
    assign w_step_angle = w_sum[ANGLE_W-1:0];
    // The result always lies between angle and target, so the carry is zero.
    assign w_unused_msb = w_sum[ANGLE_W];

    always_comb begin
        w_clamped = i_cmd_value;
        if (int'(i_cmd_value) > MAX_ANGLE) begin
            w_clamped = c_MAX;
        end else if (int'(i_cmd_value) < MIN_ANGLE) begin
            w_clamped = c_MIN;
        end
    end

    assign w_new_tgt = (i_cmd_op == OP_HOME) ? c_HOME : w_clamped;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_angle  <= c_HOME;
            r_target <= c_HOME;
            r_speed  <= c_SPEED_RST;
            r_acc    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_angle  <= w_angle_nxt;
            r_target <= w_target_nxt;
            r_speed  <= w_speed_nxt;
            r_acc    <= w_acc_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // A command to this channel takes priority over a due step; the
    // accumulator then holds its value so the step happens next cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_angle_nxt  = r_angle;
        w_target_nxt = r_target;
        w_speed_nxt  = r_speed;
        w_acc_nxt    = r_acc;
        w_done_nxt   = 1'b0;
        if (i_cmd_valid) begin
            case (i_cmd_op)
                OP_SET_ANGLE, OP_HOME: begin
                    w_target_nxt = w_new_tgt;
                    if (w_new_tgt != r_angle) begin
                        w_state_nxt = RAMP;
                    end else begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                    end
                end
                OP_SET_SPEED: begin
                    w_speed_nxt = i_cmd_value[SPEED_W-1:0];
                end
                default: begin // OP_STOP
                    w_target_nxt = r_angle;
                    w_acc_nxt    = '0;
                    w_state_nxt  = IDLE;
                end
            endcase
        end else if (r_state == RAMP) begin
            if (r_acc[ACC_W-1]) begin
                w_acc_nxt   = '0;
                w_angle_nxt = w_step_angle;
                if (w_step_angle == r_target) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end else begin
                w_acc_nxt = r_acc + ACC_W'(r_speed) + ACC_W'(1);
            end
        end
    end

    assign o_angle = r_angle;
    assign o_busy  = (r_state == RAMP);
    assign o_done  = r_done;

endmodule : servo_ramp_ch
`default_nettype wire

// File: rtl/servo_ramp_array.sv
`default_nettype none
// ============================================================================
// Module      : servo_ramp_array
// Description : Multi-channel servo angle controller. It accepts commands over a
//               valid/ready handshake, routes them to one of NUM_CH ramp
//               channels and flags commands addressed to a missing channel.
// Revision    : 1.0 - initial release
// Ports       : iClk       clock, rising edge
//               iRst       asynchronous active-high reset
//               iCmdValid  command present
//               oCmdReady  command accepted when iCmdValid & oCmdReady
//               iCmdCh     target channel
//               iCmdOp     opcode: SET_ANGLE / SET_SPEED / STOP / HOME
//               iCmdValue  angle, or speed code in the low SPEED_W bits
//               oCmdErr    one-cycle pulse: accepted command had iCmdCh >= NUM_CH
//               oAngle     packed current angles, channel 0 in the LSBs
//               oBusy      per-channel ramp in progress
//               oDone      per-channel one-cycle pulse on reaching the target
// ============================================================================
module servo_ramp_array
    import servo_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ANGLE_W    = 8,
    parameter int MIN_ANGLE  = 0,
    parameter int MAX_ANGLE  = 180,
    parameter int HOME_ANGLE = c_HOME_ANGLE,
    parameter int STEP       = c_STEP,
    parameter int SPEED_W    = 3,
    parameter int DEF_SPEED  = c_DEF_SPEED,
    parameter int ACC_W      = 22,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iCmdValid,
    output logic                      oCmdReady,
    input  logic [CH_W-1:0]           iCmdCh,
    input  logic [1:0]                iCmdOp,
    input  logic [ANGLE_W-1:0]        iCmdValue,
    output logic                      oCmdErr,
    output logic [NUM_CH*ANGLE_W-1:0] oAngle,
    output logic [NUM_CH-1:0]         oBusy,
    output logic [NUM_CH-1:0]         oDone
);

    logic r_ready;
    logic r_err;
    logic w_accept;
    logic w_ch_ok;

    assign w_accept = iCmdValid & r_ready;
    assign w_ch_ok  = (int'(iCmdCh) < NUM_CH);

    // Ready comes up on the first edge after reset and stays up: every
    // channel can absorb one command per cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_accept & ~w_ch_ok;
        end
    end

    assign oCmdReady = r_ready;
    assign oCmdErr   = r_err;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_sel;
            assign w_sel = w_accept & (iCmdCh == CH_W'(g));

            servo_ramp_ch #(
                .ANGLE_W    (ANGLE_W),
                .MIN_ANGLE  (MIN_ANGLE),
                .MAX_ANGLE  (MAX_ANGLE),
                .HOME_ANGLE (HOME_ANGLE),
                .STEP       (STEP),
                .SPEED_W    (SPEED_W),
                .DEF_SPEED  (DEF_SPEED),
                .ACC_W      (ACC_W)
            ) u_ch (
                .i_clk       (iClk),
                .i_rst       (iRst),
                .i_cmd_valid (w_sel),
                .i_cmd_op    (iCmdOp),
                .i_cmd_value (iCmdValue),
                .o_angle     (oAngle[g*ANGLE_W +: ANGLE_W]),
                .o_busy      (oBusy[g]),
                .o_done      (oDone[g])
            );
        end
    endgenerate

endmodule : servo_ramp_array
`default_nettype wire

// File: tb/tb_servo_ramp_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_ramp_array
// Description : Directed self-checking bench for servo_ramp_array with five
//               channels and a 6-bit accumulator (speed 2 -> step every 12
//               cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_ramp_array;
    import servo_pkg::*;

    localparam int NCH = 5;
    localparam int AW  = 8;
    localparam int CHW = 3;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iCmdValid;
    logic              oCmdReady;
    logic [CHW-1:0]    iCmdCh;
    logic [1:0]        iCmdOp;
    logic [AW-1:0]     iCmdValue;
    logic              oCmdErr;
    logic [NCH*AW-1:0] oAngle;
    logic [NCH-1:0]    oBusy;
    logic [NCH-1:0]    oDone;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt [NCH];

    servo_ramp_array #(
        .NUM_CH (NCH),
        .ACC_W  (6)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iCmdValid (iCmdValid),
        .oCmdReady (oCmdReady),
        .iCmdCh    (iCmdCh),
        .iCmdOp    (iCmdOp),
        .iCmdValue (iCmdValue),
        .oCmdErr   (oCmdErr),
        .oAngle    (oAngle),
        .oBusy     (oBusy),
        .oDone     (oDone)
    );

    always #5 iClk = ~iClk;

    // Count done pulses per channel, sampled mid-cycle
    initial begin
        for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
        forever begin
            @(negedge iClk);
            for (int i = 0; i < NCH; i++) if (oDone[i] === 1'b1) done_cnt[i]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] ang(input int ch);
        return oAngle[ch*AW +: AW];
    endfunction

    // Present one command from mid-cycle; it is accepted on the next edge.
    task automatic send(input logic [CHW-1:0] ch, input logic [1:0] op, input logic [AW-1:0] val);
        @(negedge iClk);
        iCmdValid = 1'b1;
        iCmdCh    = ch;
        iCmdOp    = op;
        iCmdValue = val;
        @(posedge iClk);
        #1;
        iCmdValid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    initial begin
        iRst = 1'b1; iCmdValid = 1'b0; iCmdCh = '0; iCmdOp = '0; iCmdValue = '0;
        #1;
        chk("rst_ready", oCmdReady, 0);
        repeat (3) @(posedge iClk);
        #1;
        for (int i = 0; i < NCH; i++) chk("rst_angle", ang(i), 60);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_err", oCmdErr, 0);
        @(negedge iClk); iRst = 1'b0;
        #1 chk("ready_before_edge", oCmdReady, 0);
        tick(1);
        chk("ready_after_edge", oCmdReady, 1);

        // ch0: 60 -> 90 at speed 2, one step every 12 cycles
        send(0, OP_SET_ANGLE, 8'd90);
        chk("ch0_busy_start", oBusy[0], 1);
        chk("ch0_ang_start", ang(0), 60);
        chk("err_valid_ch", oCmdErr, 0);
        for (int k = 1; k <= 6; k++) begin
            tick(11);
            chk("ch0_ang_pre", ang(0), 60 + 5*(k-1));
            tick(1);
            chk("ch0_ang_step", ang(0), 60 + 5*k);
            chk("ch0_busy", oBusy[0], (k < 6) ? 1 : 0);
            chk("ch0_done", oDone[0], (k == 6) ? 1 : 0);
            chk("ch1_still", ang(1), 60);
        end
        tick(1);
        chk("ch0_done_gone", oDone[0], 0);
        chk("ch0_done_cnt", done_cnt[0], 1);

        // ch1: small move snaps exactly, large value clamps to 180
        send(1, OP_SET_ANGLE, 8'd62);
        tick(12);
        chk("ch1_snap", ang(1), 62);
        chk("ch1_snap_busy", oBusy[1], 0);
        chk("ch1_snap_done", oDone[1], 1);
        send(1, OP_SET_ANGLE, 8'd250);
        chk("ch1_clamp_busy", oBusy[1], 1);
        tick(23*12);
        chk("ch1_clamp_pre", ang(1), 177);
        chk("ch1_clamp_busy2", oBusy[1], 1);
        tick(12);
        chk("ch1_clamp_end", ang(1), 180);
        chk("ch1_clamp_idle", oBusy[1], 0);

        // ch2: reverse mid-ramp, then STOP mid-ramp
        send(2, OP_SET_ANGLE, 8'd120);
        tick(36);
        chk("ch2_at75", ang(2), 75);
        send(2, OP_SET_ANGLE, 8'd50);
        for (int k = 1; k <= 5; k++) begin
            tick(12);
            chk("ch2_rev", ang(2), 75 - 5*k);
        end
        chk("ch2_rev_idle", oBusy[2], 0);
        tick(1);
        chk("ch2_done_cnt", done_cnt[2], 1);
        send(2, OP_SET_ANGLE, 8'd100);
        tick(24);
        chk("ch2_pre_stop", ang(2), 60);
        send(2, OP_STOP, 8'd0);
        chk("ch2_stop_busy", oBusy[2], 0);
        tick(30);
        chk("ch2_stop_ang", ang(2), 60);
        chk("ch2_stop_nodone", done_cnt[2], 1);

        // ch3: speed 7 -> 5-cycle period, speed 0 -> 33-cycle period
        send(3, OP_SET_SPEED, 8'd7);
        send(3, OP_SET_ANGLE, 8'd100);
        tick(5);
        chk("ch3_fast1", ang(3), 65);
        tick(4);
        chk("ch3_fast_pre", ang(3), 65);
        tick(1);
        chk("ch3_fast2", ang(3), 70);
        send(3, OP_SET_SPEED, 8'd0);
        tick(32);
        chk("ch3_slow_pre", ang(3), 70);
        tick(1);
        chk("ch3_slow", ang(3), 75);
        // Command on a step-due cycle suppresses that step
        send(3, OP_SET_SPEED, 8'd7);
        tick(4);
        chk("ch3_due", ang(3), 75);
        send(3, OP_SET_SPEED, 8'd7);
        chk("ch3_suppressed", ang(3), 75);
        tick(1);
        chk("ch3_late_step", ang(3), 80);
        tick(30);
        chk("ch3_end", ang(3), 100);
        chk("ch3_idle", oBusy[3], 0);

        // Out-of-range channel
        send(5, OP_SET_ANGLE, 8'd100);
        chk("err_pulse", oCmdErr, 1);
        chk("err_ch0", ang(0), 90);
        chk("err_ch1", ang(1), 180);
        chk("err_ch2", ang(2), 60);
        chk("err_ch3", ang(3), 100);
        chk("err_ch4", ang(4), 60);
        chk("err_busy", oBusy, 0);
        tick(1);
        chk("err_gone", oCmdErr, 0);

        // HOME, then asynchronous reset mid-ramp
        send(0, OP_HOME, 8'd0);
        tick(12);
        chk("ch0_home_step", ang(0), 85);
        send(4, OP_SET_ANGLE, 8'd150);
        tick(24);
        chk("ch4_mid", ang(4), 70);
        @(negedge iClk);
        #2 iRst = 1'b1;
        #1;
        for (int i = 0; i < NCH; i++) chk("arst_angle", ang(i), 60);
        chk("arst_busy", oBusy, 0);
        chk("arst_ready", oCmdReady, 0);
        @(negedge iClk); iRst = 1'b0;
        #1 chk("arst_ready_held", oCmdReady, 0);
        tick(1);
        chk("arst_ready_up", oCmdReady, 1);
        tick(30);
        chk("arst_ch0_still", ang(0), 60);
        chk("arst_ch4_still", ang(4), 60);
        chk("arst_nodone0", done_cnt[0], 1);
        chk("arst_nodone4", done_cnt[4], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_servo_ramp_array
`default_nettype wire
